// File: rtl/fp_conv_sequencer.sv
// FP32->FP16 vector sequencer: streams LENGTH elements through a LANES-wide registered
// converter one chunk per cycle and reassembles the FP16 results into one output vector.

module FpConverterFP32_8_FP16_5 #(
  parameter int LANES   = 1,
  parameter bit USE_REG = 1'b1
) (
  input  logic                   clk,
  input  logic [LANES-1:0][31:0] data_in,
  output logic [LANES-1:0][15:0] data_out
);
  logic [LANES-1:0][15:0] conv;

  // Truncating conversion; underflow is tested first so it wins over overflow.
  function automatic logic [15:0] fp32_to_fp16(input logic [31:0] f);
    logic [7:0]  e;
    logic [4:0]  e16;
    logic [15:0] r;
    e   = f[30:23];
    e16 = e[4:0] - 5'd16;
    if (e <= 8'd111)      r = {f[31], 15'd0};
    else if (e >= 8'd144) r = {f[31], 5'h1f, 10'd0};
    else                  r = {f[31], e16, f[22:13]};
    return r;
  endfunction

  always_comb begin
    conv = '0;
    for (int i = 0; i < LANES; i++) conv[i] = fp32_to_fp16(data_in[i]);
  end

  if (USE_REG) begin : g_reg
    always_ff @(posedge clk) data_out <= conv;
  end else begin : g_comb
    assign data_out = conv;
  end
endmodule

module fp_conv_sequencer #(
  parameter int LENGTH = 8,
  parameter int LANES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LENGTH-1:0][31:0] data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LENGTH-1:0][15:0] data_out,
  output logic                    busy,
  output logic [15:0]             vec_count,
  input  logic                    debugen_in
);
  localparam int CHUNKS = LENGTH / LANES;
  localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  if (LENGTH < 1) begin : g_len_chk
    $error("fp_conv_sequencer: LENGTH must be at least 1");
  end
  if (LENGTH % LANES != 0) begin : g_lanes_chk
    $error("fp_conv_sequencer: LENGTH must be a multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                    state, state_nxt;
  logic [LENGTH-1:0][31:0]   src_q;
  logic [LENGTH-1:0][15:0]   res_q;
  logic [IDX_W-1:0]          issue_idx;
  logic [IDX_W-1:0]          cap_idx;
  logic                      cap_valid;
  logic [15:0]               vec_count_q;
  logic                      accept;
  logic                      issue;
  logic                      complete;
  logic [LANES-1:0][31:0]    conv_in;
  logic [LANES-1:0][15:0]    conv_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    issue     = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = !reset;
        accept   = in_valid && !reset;
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        issue = 1'b1;
        if (issue_idx == IDX_W'(CHUNKS - 1)) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        complete  = out_ready;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    conv_in = src_q[LANES-1:0];
    for (int c = 0; c < CHUNKS; c++)
      if (issue_idx == IDX_W'(c)) conv_in = src_q[c*LANES +: LANES];
  end

  FpConverterFP32_8_FP16_5 #(.LANES(LANES), .USE_REG(1'b1)) u_conv (
    .clk      (clk),
    .data_in  (conv_in),
    .data_out (conv_out)
  );

  // The converter register has one cycle of latency, so captures trail issues by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q       <= '0;
      res_q       <= '0;
      issue_idx   <= '0;
      cap_idx     <= '0;
      cap_valid   <= 1'b0;
      vec_count_q <= '0;
    end else begin
      cap_valid <= issue;
      cap_idx   <= issue_idx;
      if (accept) begin
        src_q     <= data_in;
        issue_idx <= '0;
      end else if (issue) begin
        issue_idx <= issue_idx + 1'b1;
      end
      if (cap_valid)
        for (int c = 0; c < CHUNKS; c++)
          if (cap_idx == IDX_W'(c)) res_q[c*LANES +: LANES] <= conv_out;
      if (complete) vec_count_q <= vec_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (debugen_in && accept)   $write("fp_conv_sequencer: accept vector\n");
    if (debugen_in && complete) $write("fp_conv_sequencer: output vector %0d\n", vec_count_q);
  end

  assign data_out  = res_q;
  assign vec_count = vec_count_q;
endmodule

// File: tb/tb_fp_conv_sequencer.sv
// Directed bench for fp_conv_sequencer: table of hand-converted vectors plus
// backpressure, reset and back-to-back sequences on three parameterisations.
module tb_fp_conv_sequencer;
  logic clk;
  logic reset;

  logic             in_valid_a, out_ready_a, in_ready_a, out_valid_a, busy_a;
  logic [7:0][31:0] data_in_a;
  logic [7:0][15:0] data_out_a;
  logic [15:0]      vec_count_a;

  logic             in_valid_b, out_ready_b, in_ready_b, out_valid_b, busy_b;
  logic [3:0][31:0] data_in_b;
  logic [3:0][15:0] data_out_b;
  logic [15:0]      vec_count_b;

  logic             in_valid_c, out_ready_c, in_ready_c, out_valid_c, busy_c;
  logic [7:0][31:0] data_in_c;
  logic [7:0][15:0] data_out_c;
  logic [15:0]      vec_count_c;

  int               sel;
  logic             g_in_valid, g_out_ready, g_in_ready, g_out_valid;
  logic [127:0]     g_data_out;
  logic [15:0]      g_vec_count;

  int total;
  int bad;

  typedef struct {
    logic [7:0][31:0] din;
    logic [7:0][15:0] dout;
  } vec_t;
  vec_t tbl [4];

  fp_conv_sequencer #(.LENGTH(8), .LANES(2)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .data_in(data_in_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .data_out(data_out_a), .busy(busy_a), .vec_count(vec_count_a), .debugen_in(1'b0)
  );

  fp_conv_sequencer #(.LENGTH(4), .LANES(4)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .data_in(data_in_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .data_out(data_out_b), .busy(busy_b), .vec_count(vec_count_b), .debugen_in(1'b0)
  );

  fp_conv_sequencer #(.LENGTH(8), .LANES(1)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .data_in(data_in_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
    .data_out(data_out_c), .busy(busy_c), .vec_count(vec_count_c), .debugen_in(1'b0)
  );

  assign in_valid_b  = (sel == 0) && g_in_valid;
  assign out_ready_b = (sel == 0) && g_out_ready;
  assign in_valid_c  = (sel == 1) && g_in_valid;
  assign out_ready_c = (sel == 1) && g_out_ready;
  assign g_in_ready  = (sel == 0) ? in_ready_b  : in_ready_c;
  assign g_out_valid = (sel == 0) ? out_valid_b : out_valid_c;
  assign g_data_out  = (sel == 0) ? {64'd0, data_out_b} : data_out_c;
  assign g_vec_count = (sel == 0) ? vec_count_b : vec_count_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One vector through dut_a with out_ready held high; checks latency, result and count.
  task automatic run_a(input int idx, input logic [15:0] vc_exp, input string nm);
    int lat;
    @(negedge clk);
    chk({nm, "_in_ready"}, in_ready_a, 1);
    in_valid_a  = 1'b1;
    data_in_a   = tbl[idx].din;
    out_ready_a = 1'b1;
    @(negedge clk);
    in_valid_a = 1'b0;
    data_in_a  = ~tbl[idx].din;
    chk({nm, "_busy"}, busy_a, 1);
    lat = 0;
    while (!out_valid_a && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, 5);
    chk({nm, "_data"}, data_out_a, tbl[idx].dout);
    @(negedge clk);
    chk({nm, "_vec_count"}, vec_count_a, vc_exp);
    chk({nm, "_idle_after"}, {out_valid_a, in_ready_a}, 2'b01);
  endtask

  // Back-to-back run on dut_b (sel 0) or dut_c (sel 1) from a preloaded count of 0xFFFE.
  task automatic burst(input int s, input int spacing, input logic [127:0] dexp, input string nm);
    int           acc_cyc [4];
    int           n_acc;
    int           n_vc;
    logic         hs_last;
    logic [15:0]  vc_seen [3];
    logic [127:0] last_dat;
    sel      = s;
    n_acc    = 0;
    n_vc     = 0;
    hs_last  = 1'b0;
    last_dat = '0;
    @(negedge clk);
    g_in_valid  = 1'b1;
    g_out_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (hs_last && n_vc < 3) begin
        vc_seen[n_vc] = g_vec_count;
        n_vc++;
      end
      hs_last = g_out_valid && g_out_ready;
      if (hs_last) last_dat = g_data_out;
      if (g_in_valid && g_in_ready && n_acc < 4) begin
        acc_cyc[n_acc] = c;
        n_acc++;
      end
      if (n_vc == 3) break;
      @(negedge clk);
    end
    g_in_valid  = 1'b0;
    g_out_ready = 1'b0;
    chk({nm, "_accepts"}, n_acc >= 3, 1);
    chk({nm, "_handshakes"}, n_vc, 3);
    if (n_acc >= 3) begin
      chk({nm, "_spacing1"}, acc_cyc[1] - acc_cyc[0], spacing);
      chk({nm, "_spacing2"}, acc_cyc[2] - acc_cyc[1], spacing);
    end
    if (n_vc == 3) begin
      chk({nm, "_vc_ffff"}, vc_seen[0], 16'hFFFF);
      chk({nm, "_vc_wrap"}, vc_seen[1], 16'h0000);
      chk({nm, "_vc_after"}, vc_seen[2], 16'h0001);
      chk({nm, "_data"}, last_dat, dexp);
    end
  endtask

  initial begin
    logic saw;
    total = 0;
    bad   = 0;
    sel   = 2;
    reset = 1'b1;
    in_valid_a = 1'b0; out_ready_a = 1'b0; data_in_a = '0;
    g_in_valid = 1'b0; g_out_ready = 1'b0;

    tbl[0].din  = {32'h3E800000, 32'h477FE000, 32'hC0000000, 32'h3F800000,
                   32'h3E800000, 32'h477FE000, 32'hC0000000, 32'h3F800000};
    tbl[0].dout = {16'h3400, 16'h7BFF, 16'hC000, 16'h3C00,
                   16'h3400, 16'h7BFF, 16'hC000, 16'h3C00};
    tbl[1].din  = {32'h38800000, 32'h80000000, 32'h47800000, 32'h7F7FFFFF,
                   32'h2EDBE6FF, 32'h00000000, 32'hFF800000, 32'h7F800000};
    tbl[1].dout = {16'h0400, 16'h8000, 16'h7C00, 16'h7C00,
                   16'h0000, 16'h0000, 16'hFC00, 16'h7C00};
    tbl[2].din  = {32'h3FC00000, 32'h7FC00000, 32'h48000000, 32'h47FFFFFF,
                   32'hC7800000, 32'h47000000, 32'h37800000, 32'h387FC000};
    tbl[2].dout = {16'h3E00, 16'h7C00, 16'h7C00, 16'h7FFF,
                   16'hFC00, 16'h7800, 16'h0000, 16'h03FE};
    tbl[3].din  = {32'h477FFFFF, 32'h3A83126F, 32'h80400000, 32'h00000001,
                   32'hC2F60000, 32'h40490FDB, 32'h3F000000, 32'hBF800000};
    tbl[3].dout = {16'h7BFF, 16'h1418, 16'h8000, 16'h0000,
                   16'hD7B0, 16'h4248, 16'h3800, 16'hBC00};
    data_in_b = tbl[0].din[3:0];
    data_in_c = tbl[3].din;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready_a, 0);
    chk("rst_out_valid_busy", {out_valid_a, busy_a}, 2'b00);
    chk("rst_vec_count", vec_count_a, 0);
    chk("rst_data_out", data_out_a, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("release_in_ready", in_ready_a, 1);

    for (int i = 0; i < 4; i++) run_a(i, 16'(i + 1), $sformatf("vec%0d", i));

    // Asynchronous reset mid-cycle clears everything without waiting for a clock edge.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_out_valid_busy", {out_valid_a, busy_a}, 2'b00);
    chk("async_rst_in_ready", in_ready_a, 0);
    chk("async_rst_vec_count", vec_count_a, 0);
    chk("async_rst_data_out", data_out_a, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("async_rel_in_ready", in_ready_a, 1);

    // Backpressure: DONE holds with new data waiting on the input.
    in_valid_a  = 1'b1;
    data_in_a   = tbl[2].din;
    out_ready_a = 1'b0;
    @(negedge clk);
    data_in_a = tbl[3].din;
    for (int k = 0; k < 20 && !out_valid_a; k++) @(negedge clk);
    chk("bp_out_valid", out_valid_a, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", k), {out_valid_a, in_ready_a, data_out_a},
          {1'b1, 1'b0, tbl[2].dout});
    end
    out_ready_a = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", {out_valid_a, in_ready_a}, 2'b01);
    chk("bp_release_count", vec_count_a, 1);
    @(negedge clk);
    in_valid_a = 1'b0;
    for (int k = 0; k < 20 && !out_valid_a; k++) @(negedge clk);
    chk("bp_second_data", data_out_a, tbl[3].dout);
    @(negedge clk);
    chk("bp_second_count", vec_count_a, 2);

    // Reset pulse while the vector is mid-ISSUE abandons it.
    @(negedge clk);
    in_valid_a = 1'b1;
    data_in_a  = tbl[0].din;
    @(negedge clk);
    in_valid_a = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid_a) saw = 1'b1;
    end
    chk("midrst_no_valid", saw, 0);
    chk("midrst_count", vec_count_a, 0);
    chk("midrst_data", data_out_a, 0);
    run_a(1, 16'd1, "after_midrst");

    // Preload both counters close to wrap, then stream back to back.
    @(negedge clk);
    force dut_b.vec_count_q = 16'hFFFE;
    force dut_c.vec_count_q = 16'hFFFE;
    @(negedge clk);
    release dut_b.vec_count_q;
    release dut_c.vec_count_q;
    burst(0, 4, {64'd0, tbl[0].dout[3:0]}, "b2b_l4");
    burst(1, 11, tbl[3].dout, "b2b_l1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
